// File: rtl/hcp_tx_pkg.sv
// ============================================================================
// Module   : hcp_tx_pkg
// Brief    : Shared field positions, stream constants, FSM encoding and the
//            reflected CRC-32 byte-update helper for the HCP TX serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hcp_tx_pkg;

  // Packet word field positions
  localparam int HEAD_BIT = 133;
  localparam int TAIL_BIT = 132;
  localparam int VLD_MSB  = 131;
  localparam int VLD_LSB  = 128;

  // Stream framing bytes
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // IEEE 802.3 polynomial, bit-reflected form
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    IDLE_S  = 3'd0,
    PREAM_S = 3'd1,
    DATA_S  = 3'd2,
    FCS_S   = 3'd3,
    IFG_S   = 3'd4
  } tx_state_e;

  // One byte of reflected CRC-32, LSB of the data byte shifted in first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_d8_hcp.sv
// ============================================================================
// Module   : crc32_d8_hcp
// Brief    : Byte-wide running CRC-32 register. Clear loads the all-ones seed;
//            enable folds in one byte. Output is the raw (un-inverted) state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_d8_hcp
  import hcp_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  iv_data,
  output logic [31:0] ov_crc
);

  logic [31:0] crc_q;

  // Running CRC state: seed on clear, update on each enabled byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (i_clr) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (i_en) begin
      crc_q <= crc32_byte(crc_q, iv_data);
    end
  end

  assign ov_crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/tx_pkt_serializer_hcp.sv
// ============================================================================
// Module   : tx_pkt_serializer_hcp
// Brief    : Serializes 134-bit HCP TX packet words into a gap-free byte
//            stream with preamble/SFD, enforced inter-frame gap, underrun and
//            format-error truncation. Optional FCS append is enabled by
//            defining HCP_TX_FCS_APPEND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_pkt_serializer_hcp
  import hcp_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned PREAMBLE_LEN = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [133:0] iv_pkt_word,
  input  logic         i_pkt_word_wr,
  output logic         o_pkt_word_rdy,
  output logic [7:0]   ov_pkt_data,
  output logic         o_pkt_data_wr,
  input  logic         i_fifo_overflow_pulse,
  output logic         o_underrun_pulse,
  output logic         o_format_err_pulse,
  output logic [31:0]  ov_tx_pkt_cnt,
  output logic [15:0]  ov_overflow_cnt
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [7:0] PRE_LEN  = 8'(PREAMBLE_LEN);

  // Two-entry word buffer: cur is being serialized, nxt is the lookahead
  logic [133:0] cur_q, cur_d, nxt_q, nxt_d;
  logic         cur_v_q, cur_v_d, nxt_v_q, nxt_v_d, rdy_q;
  logic         pop, push;

  tx_state_e    state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         drop_q, drop_d;
  logic [7:0]   data_q, data_d;
  logic         wr_q, wr_d, und_q, und_d, ferr_q, ferr_d;
  logic [31:0]  txc_q;
  logic [15:0]  ovf_q;
  logic         tx_inc;

  logic [127:0] cur_shift;
  logic [7:0]   cur_byte;
  logic [3:0]   last_idx;
  logic         cur_last;

  assign push      = i_pkt_word_wr & rdy_q;
  assign cur_shift = cur_q[127:0] << {cnt_q[3:0], 3'b000};
  assign cur_byte  = cur_shift[127:120];
  // A valid-count of 0 means 16 bytes; the 4-bit wrap of 0-1 yields 15
  assign last_idx  = cur_q[VLD_MSB:VLD_LSB] - 4'd1;
  assign cur_last  = cur_q[TAIL_BIT] ? (cnt_q[3:0] == last_idx) : (cnt_q[3:0] == 4'hF);

`ifdef HCP_TX_FCS_APPEND_EN
  logic        crc_clr, crc_en;
  logic [31:0] crc_w, fcs_w, fcs_shift;

  crc32_d8_hcp u_crc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (crc_clr),
    .i_en    (crc_en),
    .iv_data (cur_byte),
    .ov_crc  (crc_w)
  );

  assign fcs_w     = ~crc_w;
  assign fcs_shift = fcs_w >> {cnt_q[1:0], 3'b000};
`endif

  // Buffer next-state: pop shifts nxt into cur, push fills first free slot
  always_comb begin
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cur_v_d = cur_v_q;
    nxt_v_d = nxt_v_q;
    if (pop) begin
      cur_d   = nxt_q;
      cur_v_d = nxt_v_q;
      nxt_v_d = 1'b0;
    end
    if (push) begin
      if (!cur_v_d) begin
        cur_d   = iv_pkt_word;
        cur_v_d = 1'b1;
      end else begin
        nxt_d   = iv_pkt_word;
        nxt_v_d = 1'b1;
      end
    end
  end

  // Serializer FSM: next state, next registered outputs and buffer pop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    data_d  = 8'h00;
    wr_d    = 1'b0;
    und_d   = 1'b0;
    ferr_d  = 1'b0;
    pop     = 1'b0;
    tx_inc  = 1'b0;
`ifdef HCP_TX_FCS_APPEND_EN
    crc_clr = 1'b0;
    crc_en  = 1'b0;
`endif
    case (state_q)
      IDLE_S: begin
        if (cur_v_q) begin
          if (cur_q[HEAD_BIT]) begin
            // Start the frame: first preamble byte goes out on this edge
            drop_d  = 1'b0;
            data_d  = PREAMBLE_BYTE;
            wr_d    = 1'b1;
            cnt_d   = 8'd1;
            state_d = PREAM_S;
`ifdef HCP_TX_FCS_APPEND_EN
            crc_clr = 1'b1;
`endif
          end else begin
            // Leftovers of a truncated frame are silently dropped
            pop = 1'b1;
            if (drop_q) begin
              if (cur_q[TAIL_BIT]) drop_d = 1'b0;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      PREAM_S: begin
        wr_d = 1'b1;
        if (cnt_q < PRE_LEN) begin
          data_d = PREAMBLE_BYTE;
          cnt_d  = cnt_q + 8'd1;
        end else begin
          data_d  = SFD_BYTE;
          cnt_d   = 8'd0;
          state_d = DATA_S;
        end
      end
      DATA_S: begin
        wr_d   = 1'b1;
        data_d = cur_byte;
`ifdef HCP_TX_FCS_APPEND_EN
        crc_en = 1'b1;
`endif
        if (cur_last) begin
          pop   = 1'b1;
          cnt_d = 8'd0;
          if (cur_q[TAIL_BIT]) begin
`ifdef HCP_TX_FCS_APPEND_EN
            state_d = FCS_S;
`else
            state_d = IFG_S;
            tx_inc  = 1'b1;
`endif
          end else if (!nxt_v_q) begin
            und_d   = 1'b1;
            drop_d  = 1'b1;
            state_d = IFG_S;
          end else if (nxt_q[HEAD_BIT]) begin
            // Head mid-frame: truncate, keep the head for the next frame
            ferr_d  = 1'b1;
            state_d = IFG_S;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef HCP_TX_FCS_APPEND_EN
      FCS_S: begin
        wr_d   = 1'b1;
        data_d = fcs_shift[7:0];
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d   = 8'd0;
          state_d = IFG_S;
          tx_inc  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      IFG_S: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 8'd0;
          state_d = IDLE_S;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (drop_q && cur_v_q) begin
          if (cur_q[HEAD_BIT]) begin
            drop_d = 1'b0;
          end else begin
            pop = 1'b1;
            if (cur_q[TAIL_BIT]) drop_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE_S;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, buffer and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE_S;
      cnt_q   <= 8'd0;
      drop_q  <= 1'b0;
      cur_q   <= '0;
      nxt_q   <= '0;
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      und_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
      rdy_q   <= ~nxt_v_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      und_q   <= und_d;
      ferr_q  <= ferr_d;
    end
  end

  // Frame counter (wrapping) and overflow counter (saturating)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      txc_q <= 32'd0;
      ovf_q <= 16'd0;
    end else begin
      if (tx_inc) txc_q <= txc_q + 32'd1;
      if (i_fifo_overflow_pulse && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign o_pkt_word_rdy     = rdy_q;
  assign ov_pkt_data        = data_q;
  assign o_pkt_data_wr      = wr_q;
  assign o_underrun_pulse   = und_q;
  assign o_format_err_pulse = ferr_q;
  assign ov_tx_pkt_cnt      = txc_q;
  assign ov_overflow_cnt    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_pkt_serializer_hcp.sv
// ============================================================================
// Module   : tb_tx_pkt_serializer_hcp
// Brief    : Directed self-checking bench for tx_pkt_serializer_hcp.
//            Expectations adapt to HCP_TX_FCS_APPEND_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_pkt_serializer_hcp;

`ifdef HCP_TX_FCS_APPEND_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [133:0] iv_pkt_word = '0;
  logic         i_pkt_word_wr = 1'b0;
  logic         o_pkt_word_rdy;
  logic [7:0]   ov_pkt_data;
  logic         o_pkt_data_wr;
  logic         i_fifo_overflow_pulse = 1'b0;
  logic         o_underrun_pulse;
  logic         o_format_err_pulse;
  logic [31:0]  ov_tx_pkt_cnt;
  logic [15:0]  ov_overflow_cnt;

  always #4 clk = ~clk;

  tx_pkt_serializer_hcp #(.IFG_CYCLES(12), .PREAMBLE_LEN(7)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .iv_pkt_word           (iv_pkt_word),
    .i_pkt_word_wr         (i_pkt_word_wr),
    .o_pkt_word_rdy        (o_pkt_word_rdy),
    .ov_pkt_data           (ov_pkt_data),
    .o_pkt_data_wr         (o_pkt_data_wr),
    .i_fifo_overflow_pulse (i_fifo_overflow_pulse),
    .o_underrun_pulse      (o_underrun_pulse),
    .o_format_err_pulse    (o_format_err_pulse),
    .ov_tx_pkt_cnt         (ov_tx_pkt_cnt),
    .ov_overflow_cnt       (ov_overflow_cnt)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] bq[$];
  int         sq[$];
  int         cyc    = 0;
  int         un_cnt = 0;
  int         fe_cnt = 0;

  // Output monitor: captures every emitted byte with its cycle stamp
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (o_pkt_data_wr) begin
        bq.push_back(ov_pkt_data);
        sq.push_back(cyc);
      end
      if (o_underrun_pulse)   un_cnt = un_cnt + 1;
      if (o_format_err_pulse) fe_cnt = fe_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] mk_word(input logic [7:0] b);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = b + 8'(i);
    return w;
  endfunction

  task automatic send(input logic h, input logic t, input logic [3:0] v, input logic [127:0] d);
    int to;
    to = 0;
    @(negedge clk);
    while (!o_pkt_word_rdy && to < 200) begin
      @(negedge clk);
      to++;
    end
    if (to >= 200) chk("rdy_timeout", {31'd0, o_pkt_word_rdy}, 32'd1);
    iv_pkt_word   = {h, t, v, d};
    i_pkt_word_wr = 1'b1;
    @(posedge clk);
    #1 i_pkt_word_wr = 1'b0;
  endtask

  task automatic clr_q();
    bq.delete();
    sq.delete();
  endtask

  // Preamble/SFD, n data bytes base+i, and gap-free span including nf trailing bytes
  task automatic chk_frame(input string tag, input int off, input logic [7:0] base,
                           input int n, input int nf);
    int errs;
    int last;
    errs = 0;
    last = off + 8 + n + nf - 1;
    if (bq.size() <= last) begin
      chk({tag, "_len"}, 32'(bq.size()), 32'(last + 1));
      return;
    end
    for (int i = 0; i < 8; i++) if (bq[off + i] !== ((i == 7) ? 8'hD5 : 8'h55)) errs++;
    for (int i = 0; i < n; i++) if (bq[off + 8 + i] !== base + 8'(i)) errs++;
    chk({tag, "_bytes"}, 32'(errs), 32'd0);
    chk({tag, "_span"}, 32'(sq[last] - sq[off]), 32'(last - off));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy",   {31'd0, o_pkt_word_rdy}, 32'd0);
    chk("rst_wr",    {31'd0, o_pkt_data_wr},  32'd0);
    chk("rst_txcnt", ov_tx_pkt_cnt,           32'd0);
    chk("rst_ovf",   {16'd0, ov_overflow_cnt}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdy_after_rst", {31'd0, o_pkt_word_rdy}, 32'd1);

    // 4-word frame, tail vld=0 (16 bytes)
    clr_q();
    send(1'b1, 1'b0, 4'd0, mk_word(8'h00));
    chk("lat_n_wr", {31'd0, o_pkt_data_wr}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n1_wr",   {31'd0, o_pkt_data_wr}, 32'd1);
    chk("lat_n1_data", {24'd0, ov_pkt_data},   32'h55);
    send(1'b0, 1'b0, 4'd0, mk_word(8'h10));
    send(1'b0, 1'b0, 4'd0, mk_word(8'h20));
    send(1'b0, 1'b1, 4'd0, mk_word(8'h30));
    repeat (120) @(negedge clk);
    chk("t1_size", 32'(bq.size()), 32'(72 + FCS_N));
    chk_frame("t1", 0, 8'h00, 64, FCS_N);
    chk("t1_txcnt", ov_tx_pkt_cnt, 32'd1);

    // 2-word frame, tail vld=5 -> 21 data bytes
    clr_q();
    send(1'b1, 1'b0, 4'd0, mk_word(8'h40));
    send(1'b0, 1'b1, 4'd5, mk_word(8'h50));
    repeat (100) @(negedge clk);
    chk("t2_size", 32'(bq.size()), 32'(29 + FCS_N));
    chk_frame("t2", 0, 8'h40, 21, FCS_N);
    chk("t2_txcnt", ov_tx_pkt_cnt, 32'd2);

    // Back-to-back frames: exact 12-cycle gap
    clr_q();
    send(1'b1, 1'b0, 4'd0, mk_word(8'h60));
    send(1'b0, 1'b1, 4'd0, mk_word(8'h70));
    send(1'b1, 1'b1, 4'd3, mk_word(8'h90));
    repeat (150) @(negedge clk);
    chk("t3_size", 32'(bq.size()), 32'(51 + 2*FCS_N));
    chk_frame("t3a", 0, 8'h60, 32, FCS_N);
    chk_frame("t3b", 40 + FCS_N, 8'h90, 3, FCS_N);
    if (bq.size() > 40 + FCS_N)
      chk("t3_gap", 32'(sq[40 + FCS_N] - sq[39 + FCS_N]), 32'd13);
    chk("t3_txcnt", ov_tx_pkt_cnt, 32'd4);

    // Underrun: second word arrives late, rest of frame dropped
    clr_q();
    send(1'b1, 1'b0, 4'd0, mk_word(8'hA0));
    repeat (40) @(negedge clk);
    send(1'b0, 1'b0, 4'd0, mk_word(8'hB0));
    send(1'b0, 1'b1, 4'd7, mk_word(8'hC0));
    repeat (40) @(negedge clk);
    chk("t4_size", 32'(bq.size()), 32'd24);
    chk_frame("t4", 0, 8'hA0, 16, 0);
    chk("t4_und",   32'(un_cnt), 32'd1);
    chk("t4_fe",    32'(fe_cnt), 32'd0);
    chk("t4_txcnt", ov_tx_pkt_cnt, 32'd4);

    // Clean single-word frame after the underrun
    clr_q();
    send(1'b1, 1'b1, 4'd0, mk_word(8'hE0));
    repeat (60) @(negedge clk);
    chk("t4c_size", 32'(bq.size()), 32'(24 + FCS_N));
    chk_frame("t4c", 0, 8'hE0, 16, FCS_N);
    chk("t4c_txcnt", ov_tx_pkt_cnt, 32'd5);
    chk("t4c_und",   32'(un_cnt), 32'd1);

    // Non-head word in IDLE
    clr_q();
    send(1'b0, 1'b0, 4'd0, mk_word(8'h11));
    repeat (10) @(negedge clk);
    chk("t5_fe",   32'(fe_cnt), 32'd1);
    chk("t5_size", 32'(bq.size()), 32'd0);

    // "123456789" single-word frame, vld=9
    clr_q();
    send(1'b1, 1'b1, 4'd9, mk_word(8'h31));
    repeat (60) @(negedge clk);
    chk("t6_size", 32'(bq.size()), 32'(17 + FCS_N));
    chk_frame("t6", 0, 8'h31, 9, FCS_N);
`ifdef HCP_TX_FCS_APPEND_EN
    if (bq.size() >= 21)
      chk("t6_fcs", {bq[17], bq[18], bq[19], bq[20]}, 32'h2639F4CB);
`endif
    chk("t6_txcnt", ov_tx_pkt_cnt, 32'd6);

    // Reset mid-frame flushes everything
    clr_q();
    send(1'b1, 1'b0, 4'd0, mk_word(8'h00));
    send(1'b0, 1'b0, 4'd0, mk_word(8'h10));
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_wr",    {31'd0, o_pkt_data_wr}, 32'd0);
    chk("t7_rst_txcnt", ov_tx_pkt_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_q();
    repeat (40) @(negedge clk);
    chk("t7_size",  32'(bq.size()), 32'd0);
    chk("t7_txcnt", ov_tx_pkt_cnt, 32'd0);

    // Overflow counter saturation over 70000 pulses
    i_fifo_overflow_pulse = 1'b1;
    repeat (65534) @(negedge clk);
    i_fifo_overflow_pulse = 1'b0;
    chk("t8_ovf_fffe", {16'd0, ov_overflow_cnt}, 32'h0000FFFE);
    i_fifo_overflow_pulse = 1'b1;
    repeat (4466) @(negedge clk);
    i_fifo_overflow_pulse = 1'b0;
    @(negedge clk);
    chk("t8_ovf_sat", {16'd0, ov_overflow_cnt}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
